// File: rtl/spi_fsm_pkg.sv
// spi_fsm_pkg: state encoding, word size and R/W flag polarity for the SPI slave control FSM
package spi_fsm_pkg;
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    GOT_ADDR     = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_RECV   = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_e;
  localparam int WORD_BITS_DEF = 8;
  localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: edge counter with sync clear, increment enable and a word-complete flag
module spi_bit_counter #(
  parameter int CNT_W     = 4,
  parameter int WORD_BITS = 8
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_o  = cnt_q;
  assign term_o = cnt_q == CNT_W'(WORD_BITS);
endmodule

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: sequences address latch, data memory, shift-register load and MISO enable
// over one address byte followed by one data byte.
module spi_slave_fsm
  import spi_fsm_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_posedge,
  input  logic sclk_negedge,
  input  logic sr_lsb,
  output logic addr_we,
  output logic dm_we,
  output logic sr_we,
  output logic miso_buff
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic term, inc, clr;
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         state_d = cs_n ? IDLE : GET_ADDR;
      GET_ADDR:     state_d = term ? GOT_ADDR : GET_ADDR;
      GOT_ADDR:     state_d = (sr_lsb == RW_READ) ? READ_LOAD : WRITE_RECV;
      READ_LOAD:    state_d = READ_SHIFT;
      READ_SHIFT:   state_d = term ? DONE : READ_SHIFT;
      WRITE_RECV:   state_d = term ? WRITE_COMMIT : WRITE_RECV;
      WRITE_COMMIT: state_d = DONE;
      DONE:         state_d = DONE;
    endcase
    // chip-select release overrides every other transition, including a completing edge
    if (cs_n && state_q != IDLE) state_d = IDLE;
  end
  assign inc = ((state_q == GET_ADDR || state_q == WRITE_RECV) && sclk_posedge)
             || (state_q == READ_SHIFT && sclk_negedge);
  assign clr = reset || (state_d != state_q);
  spi_bit_counter #(.CNT_W(CNT_W), .WORD_BITS(WORD_BITS)) u_cnt (
    .clk    (clk),
    .clr_i  (clr),
    .inc_i  (inc),
    .cnt_o  (cnt),
    .term_o (term)
  );
  always_comb begin
    addr_we   = state_q == GOT_ADDR;
    sr_we     = state_q == READ_LOAD;
    miso_buff = state_q == READ_SHIFT;
    dm_we     = state_q == WRITE_COMMIT;
  end
endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: directed read, write, abort and reset-collision sequences for spi_slave_fsm
module tb_spi_slave_fsm;
  import spi_fsm_pkg::*;
  logic clk = 0, reset = 1, cs_n = 1, sclk_posedge = 0, sclk_negedge = 0, sr_lsb = 0;
  logic addr_we, dm_we, sr_we, miso_buff;
  int n_chk = 0, n_pass = 0;
  int n_addr = 0, n_dm = 0, n_sr = 0, n_miso = 0;
  int b_addr, b_dm, b_sr, b_miso;
  spi_slave_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .sr_lsb       (sr_lsb),
    .addr_we      (addr_we),
    .dm_we        (dm_we),
    .sr_we        (sr_we),
    .miso_buff    (miso_buff)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    n_addr += int'(addr_we);
    n_dm   += int'(dm_we);
    n_sr   += int'(sr_we);
    n_miso += int'(miso_buff);
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_pos();
    sclk_posedge = 1;
    tick();
    sclk_posedge = 0;
    tick();
  endtask
  task automatic pulse_neg();
    sclk_negedge = 1;
    tick();
    sclk_negedge = 0;
    tick();
  endtask
  task automatic outs(input string tag, input int a, input int d, input int s, input int m);
    chk({tag, ".addr_we"}, int'(addr_we), a);
    chk({tag, ".dm_we"}, int'(dm_we), d);
    chk({tag, ".sr_we"}, int'(sr_we), s);
    chk({tag, ".miso_buff"}, int'(miso_buff), m);
  endtask
  task automatic snap();
    b_addr = n_addr; b_dm = n_dm; b_sr = n_sr; b_miso = n_miso;
  endtask
  task automatic addr_phase(input logic rw);
    cs_n = 0;
    sr_lsb = rw;
    tick();
    for (int i = 0; i < 8; i++) pulse_pos();
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst.state", int'(dut.state_q), int'(IDLE));
    chk("rst.cnt", int'(dut.cnt), 0);
    outs("rst", 0, 0, 0, 0);
    // read transaction
    snap();
    addr_phase(1'b1);
    chk("rd.state_got", int'(dut.state_q), int'(GOT_ADDR));
    outs("rd.got", 1, 0, 0, 0);
    tick();
    outs("rd.load", 0, 0, 1, 0);
    tick();
    outs("rd.shift", 0, 0, 0, 1);
    pulse_pos();
    chk("rd.pos_ignored", int'(dut.cnt), 0);
    for (int i = 0; i < 7; i++) pulse_neg();
    chk("rd.cnt7", int'(dut.cnt), 7);
    chk("rd.miso7", int'(miso_buff), 1);
    pulse_neg();
    chk("rd.state_done", int'(dut.state_q), int'(DONE));
    outs("rd.done", 0, 0, 0, 0);
    chk("rd.addr_pulses", n_addr - b_addr, 1);
    chk("rd.sr_pulses", n_sr - b_sr, 1);
    chk("rd.dm_pulses", n_dm - b_dm, 0);
    cs_n = 1;
    tick();
    chk("rd.idle", int'(dut.state_q), int'(IDLE));
    // write transaction
    snap();
    addr_phase(1'b0);
    outs("wr.got", 1, 0, 0, 0);
    tick();
    chk("wr.state_recv", int'(dut.state_q), int'(WRITE_RECV));
    pulse_neg();
    chk("wr.neg_ignored", int'(dut.cnt), 0);
    for (int i = 0; i < 7; i++) pulse_pos();
    chk("wr.no_early_dm", n_dm - b_dm, 0);
    pulse_pos();
    chk("wr.state_commit", int'(dut.state_q), int'(WRITE_COMMIT));
    outs("wr.commit", 0, 1, 0, 0);
    tick();
    outs("wr.done", 0, 0, 0, 0);
    chk("wr.dm_pulses", n_dm - b_dm, 1);
    chk("wr.sr_pulses", n_sr - b_sr, 0);
    chk("wr.miso_cycles", n_miso - b_miso, 0);
    cs_n = 1;
    tick();
    // aborted write then a full write
    snap();
    addr_phase(1'b0);
    tick();
    for (int i = 0; i < 5; i++) pulse_pos();
    chk("ab.cnt5", int'(dut.cnt), 5);
    cs_n = 1;
    tick();
    chk("ab.idle", int'(dut.state_q), int'(IDLE));
    chk("ab.cnt_clr", int'(dut.cnt), 0);
    tick();
    tick();
    chk("ab.no_dm", n_dm - b_dm, 0);
    addr_phase(1'b0);
    tick();
    for (int i = 0; i < 8; i++) pulse_pos();
    chk("ab.next_commit", int'(dm_we), 1);
    tick();
    cs_n = 1;
    tick();
    chk("ab.next_dm_pulses", n_dm - b_dm, 1);
    // cs_n rising together with the 8th address edge
    snap();
    cs_n = 0;
    tick();
    for (int i = 0; i < 7; i++) pulse_pos();
    sclk_posedge = 1;
    cs_n = 1;
    tick();
    sclk_posedge = 0;
    chk("sim.idle", int'(dut.state_q), int'(IDLE));
    tick();
    tick();
    chk("sim.no_addr_we", n_addr - b_addr, 0);
    // reset during READ_SHIFT
    addr_phase(1'b1);
    tick();
    tick();
    chk("rst_mid.in_shift", int'(miso_buff), 1);
    for (int i = 0; i < 3; i++) pulse_neg();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mid.state", int'(dut.state_q), int'(IDLE));
    chk("rst_mid.cnt", int'(dut.cnt), 0);
    outs("rst_mid", 0, 0, 0, 0);
    cs_n = 1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
